// File: rtl/uart_tx_param_if.sv
// Valid/ready word interface feeding the parametrised UART transmitter.
interface uart_tx_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter on the system clock with an internal baud-tick counter.
// Frame: start, DATA_BITS LSB first, optional even/odd parity, 1 or 2 stop bits.
module uart_tx_param #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_param_if.slave   in_if,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);
    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned TICK_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W  = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 2;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
            (STOP_BITS != 1 && STOP_BITS != 2) || CLKS_PER_BIT < 2) begin : g_param_check
            $error("uart_tx_param: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic [TICK_W-1:0]    tick;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;

    assign in_if.in_ready = (state == S_IDLE) & ~rst;

    // Frame sequencer; tx is set on the same edge the state advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            tick       <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (in_if.in_valid) begin
                        shreg   <= in_if.in_data;
                        par_bit <= (PARITY == 2) ? ~^in_if.in_data : ^in_if.in_data;
                        state   <= S_START;
                        busy    <= 1'b1;
                        tx      <= 1'b0;
                        tick    <= '0;
                        bit_cnt <= '0;
                    end
                end
                default: begin
                    if (tick != TICK_LAST) begin
                        tick <= tick + TICK_W'(1);
                    end else begin
                        tick <= '0;
                        case (state)
                            S_START: begin
                                state   <= S_DATA;
                                tx      <= shreg[0];
                                shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
                                bit_cnt <= '0;
                            end
                            S_DATA: begin
                                if (bit_cnt != DATA_LAST) begin
                                    bit_cnt <= bit_cnt + BIT_W'(1);
                                    tx      <= shreg[0];
                                    shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
                                end else begin
                                    bit_cnt <= '0;
                                    if (PARITY != 0) begin
                                        state <= S_PARITY;
                                        tx    <= par_bit;
                                    end else begin
                                        state <= S_STOP;
                                        tx    <= 1'b1;
                                    end
                                end
                            end
                            S_PARITY: begin
                                state   <= S_STOP;
                                tx      <= 1'b1;
                                bit_cnt <= '0;
                            end
                            S_STOP: begin
                                tx <= 1'b1;
                                if (bit_cnt != STOP_LAST) begin
                                    bit_cnt <= bit_cnt + BIT_W'(1);
                                end else begin
                                    bit_cnt    <= '0;
                                    state      <= S_IDLE;
                                    busy       <= 1'b0;
                                    frame_done <= 1'b1;
                                end
                            end
                            default: begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                                tx    <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations (8N1, 8E1, 8O1, 7N2) checked against a frame-level model.
`timescale 1ns/1ps
module tb_uart_tx_param;
    localparam int C = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] v = 4'b0;
    logic [8:0] d [4];
    logic [3:0] rdy, tx_v, busy_v, fd_v;

    int db_c[4]  = '{8, 8, 8, 7};
    int par_c[4] = '{0, 1, 2, 0};
    int sb_c[4]  = '{1, 1, 1, 2};

    int n_cmp = 0;
    int n_bad = 0;

    logic cap_tx[512];
    logic cap_busy[512];
    logic cap_fd[512];

    always #5 clk = ~clk;

    uart_tx_param_if #(.DATA_BITS(8)) if0 ();
    uart_tx_param_if #(.DATA_BITS(8)) if1 ();
    uart_tx_param_if #(.DATA_BITS(8)) if2 ();
    uart_tx_param_if #(.DATA_BITS(7)) if3 ();

    assign if0.in_data = d[0][7:0];
    assign if1.in_data = d[1][7:0];
    assign if2.in_data = d[2][7:0];
    assign if3.in_data = d[3][6:0];
    assign if0.in_valid = v[0];
    assign if1.in_valid = v[1];
    assign if2.in_valid = v[2];
    assign if3.in_valid = v[3];
    assign rdy = {if3.in_ready, if2.in_ready, if1.in_ready, if0.in_ready};

    uart_tx_param #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .in_if(if0.slave), .tx(tx_v[0]), .busy(busy_v[0]), .frame_done(fd_v[0]));
    uart_tx_param #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .in_if(if1.slave), .tx(tx_v[1]), .busy(busy_v[1]), .frame_done(fd_v[1]));
    uart_tx_param #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .in_if(if2.slave), .tx(tx_v[2]), .busy(busy_v[2]), .frame_done(fd_v[2]));
    uart_tx_param #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst(rst), .in_if(if3.slave), .tx(tx_v[3]), .busy(busy_v[3]), .frame_done(fd_v[3]));

    // Reference model: frame as a list of bit slots, each C clocks long.
    function automatic int nbits(input int k);
        return 1 + db_c[k] + ((par_c[k] != 0) ? 1 : 0) + sb_c[k];
    endfunction

    function automatic int frame_len(input int k);
        return nbits(k) * C;
    endfunction

    function automatic logic exp_tx(input int k, input logic [8:0] w, input int n);
        int b;
        int ones;
        b = n / C;
        if (n < 0 || b >= nbits(k)) return 1'b1;
        if (b == 0) return 1'b0;
        if (b <= db_c[k]) return w[b-1];
        if (par_c[k] != 0 && b == db_c[k] + 1) begin
            ones = 0;
            for (int i = 0; i < db_c[k]; i++) ones += int'(w[i]);
            return (par_c[k] == 1) ? 1'(ones % 2) : 1'(1 - ones % 2);
        end
        return 1'b1;
    endfunction

    // Present a word and return #1 after the accepting edge.
    task automatic start_word(input int k, input logic [8:0] w, input bit hold);
        int guard;
        guard = 0;
        d[k] = w;
        v[k] = 1'b1;
        while (rdy[k] !== 1'b1 && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        n_cmp++;
        if (rdy[k] !== 1'b1) begin
            n_bad++;
            $display("FAIL accept_wait dut%0d: in_ready=%b required 1", k, rdy[k]);
        end
        @(posedge clk); #1;
        if (!hold) v[k] = 1'b0;
    endtask

    task automatic capture(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            cap_tx[i]   = tx_v[k];
            cap_busy[i] = busy_v[k];
            cap_fd[i]   = fd_v[k];
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) d[k] = '0;
        rst = 1'b1;
        v = 4'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({tx_v[k], busy_v[k], fd_v[k], rdy[k]} !== 4'b1000) begin
                n_bad++;
                $display("FAIL reset_state dut%0d: tx/busy/fd/rdy=%b required 1000", k,
                         {tx_v[k], busy_v[k], fd_v[k], rdy[k]});
            end
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({tx_v[k], busy_v[k], fd_v[k], rdy[k]} !== 4'b1001) begin
                n_bad++;
                $display("FAIL reset_release dut%0d: tx/busy/fd/rdy=%b required 1001", k,
                         {tx_v[k], busy_v[k], fd_v[k], rdy[k]});
            end
        end
    endtask

    task automatic test_frames();
        logic [8:0] w;
        logic [9:0] obs;
        int len;
        int highs;
        logic [8:0] spec_w[4] = '{9'h42, 9'h07, 9'h07, 9'h55};
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < 4; r++) begin
                w = (r == 0) ? spec_w[k] : 9'($urandom_range(0, (1 << db_c[k]) - 1));
                @(posedge clk); #1;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                start_word(k, w, 1'b0);
                len = frame_len(k);
                capture(k, len + 2);
                for (int n = 0; n < len + 2; n++) begin
                    n_cmp++;
                    if ({cap_tx[n], cap_busy[n], cap_fd[n]} !== {exp_tx(k, w, n), n < len, n == len}) begin
                        n_bad++;
                        $display("FAIL frame dut%0d w=%h cyc%0d: tx/busy/fd=%b%b%b required %b%b%b", k, w, n,
                                 cap_tx[n], cap_busy[n], cap_fd[n], exp_tx(k, w, n), n < len, n == len);
                    end
                end
                if (r == 0 && k == 0) begin
                    for (int i = 0; i < 10; i++) obs[i] = cap_tx[i*C + C/2];
                    n_cmp++;
                    if (obs !== 10'b1010000100) begin
                        n_bad++;
                        $display("FAIL frame_8n1_42 bits=%b required 1010000100", obs);
                    end
                end
                if (r == 0 && (k == 1 || k == 2)) begin
                    n_cmp++;
                    if (cap_tx[9*C + C/2] !== ((k == 1) ? 1'b1 : 1'b0) || len != 110) begin
                        n_bad++;
                        $display("FAIL parity_07 dut%0d: bit=%b required %b", k, cap_tx[9*C + C/2], (k == 1));
                    end
                end
                if (r == 0 && k == 3) begin
                    highs = 0;
                    for (int n = 8*C; n < len; n++) highs += int'(cap_tx[n]);
                    n_cmp++;
                    if (highs != 20) begin
                        n_bad++;
                        $display("FAIL stop_7n2: high clks=%0d required 20", highs);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int len;
        logic et, eb, ef;
        len = frame_len(0);
        @(posedge clk); #1;
        start_word(0, 9'hA5, 1'b1);
        d[0] = 9'h3C;
        for (int n = 0; n <= 2*len + 2; n++) begin
            et = (n < len) ? exp_tx(0, 9'hA5, n) : (n == len) ? 1'b1 : exp_tx(0, 9'h3C, n - len - 1);
            eb = (n < len) || (n > len && n - len - 1 < len);
            ef = (n == len) || (n == 2*len + 1);
            n_cmp++;
            if ({tx_v[0], busy_v[0], fd_v[0]} !== {et, eb, ef}) begin
                n_bad++;
                $display("FAIL back_to_back cyc%0d: tx/busy/fd=%b%b%b required %b%b%b", n,
                         tx_v[0], busy_v[0], fd_v[0], et, eb, ef);
            end
            if (n == len) begin
                n_cmp++;
                if (rdy[0] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL back_to_back_ready: in_ready=%b required 1", rdy[0]);
                end
            end
            if (n == len + 1) v[0] = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [8:0] w;
        int len;
        len = frame_len(0);
        @(posedge clk); #1;
        start_word(0, 9'($urandom_range(0, 255)), 1'b0);
        repeat (4*C + 5) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (rdy[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready_low: in_ready=%b required 0", rdy[0]);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({tx_v[0], busy_v[0], fd_v[0]} !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_abort: tx/busy/fd=%b required 100", {tx_v[0], busy_v[0], fd_v[0]});
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (rdy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready_high: in_ready=%b required 1", rdy[0]);
        end
        w = 9'($urandom_range(0, 255));
        start_word(0, w, 1'b0);
        capture(0, len + 2);
        for (int n = 0; n < len + 2; n++) begin
            n_cmp++;
            if ({cap_tx[n], cap_busy[n], cap_fd[n]} !== {exp_tx(0, w, n), n < len, n == len}) begin
                n_bad++;
                $display("FAIL post_reset_frame cyc%0d: tx/busy/fd=%b%b%b required %b%b%b", n,
                         cap_tx[n], cap_busy[n], cap_fd[n], exp_tx(0, w, n), n < len, n == len);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [8:0] w;
        int len;
        len = frame_len(0);
        w = 9'($urandom_range(0, 254));
        @(posedge clk); #1;
        start_word(0, w, 1'b0);
        for (int n = 0; n < len + 6; n++) begin
            n_cmp++;
            if ({tx_v[0], busy_v[0], fd_v[0]} !== {exp_tx(0, w, n), n < len, n == len}) begin
                n_bad++;
                $display("FAIL busy_ignore cyc%0d: tx/busy/fd=%b%b%b required %b%b%b", n,
                         tx_v[0], busy_v[0], fd_v[0], exp_tx(0, w, n), n < len, n == len);
            end
            if (n == 30) begin
                d[0] = 9'hFF;
                v[0] = 1'b1;
            end
            if (n == 31) begin
                v[0] = 1'b0;
                d[0] = 9'($urandom_range(0, 255));
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frames();
        test_back_to_back();
        test_reset_mid_frame();
        test_busy_ignore();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
